// File: rtl/sap_pkg.sv
// sap_pkg: SAP-1 control-word bit positions, masks, flag indices and opcodes.
package sap_pkg;
    localparam int HALT = 15;
    localparam int MI   = 14;
    localparam int RI   = 13;
    localparam int RO   = 12;
    localparam int IO   = 11;
    localparam int II   = 10;
    localparam int AI   = 9;
    localparam int AO   = 8;
    localparam int SMO  = 7;
    localparam int SU   = 6;
    localparam int BI   = 5;
    localparam int OI   = 4;
    localparam int CE   = 3;
    localparam int CO   = 2;
    localparam int JE   = 1;
    localparam int FI   = 0;

    localparam logic [15:0] M_HALT = 16'(1) << HALT;
    localparam logic [15:0] M_MI   = 16'(1) << MI;
    localparam logic [15:0] M_RI   = 16'(1) << RI;
    localparam logic [15:0] M_RO   = 16'(1) << RO;
    localparam logic [15:0] M_IO   = 16'(1) << IO;
    localparam logic [15:0] M_II   = 16'(1) << II;
    localparam logic [15:0] M_AI   = 16'(1) << AI;
    localparam logic [15:0] M_AO   = 16'(1) << AO;
    localparam logic [15:0] M_SMO  = 16'(1) << SMO;
    localparam logic [15:0] M_SU   = 16'(1) << SU;
    localparam logic [15:0] M_BI   = 16'(1) << BI;
    localparam logic [15:0] M_OI   = 16'(1) << OI;
    localparam logic [15:0] M_CE   = 16'(1) << CE;
    localparam logic [15:0] M_CO   = 16'(1) << CO;
    localparam logic [15:0] M_JE   = 16'(1) << JE;
    localparam logic [15:0] M_FI   = 16'(1) << FI;

    localparam int FLAG_C = 7;
    localparam int FLAG_Z = 6;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;
endpackage

// File: rtl/sap_datapath_alu.sv
// sap_alu: combinational add/subtract of A and B; subtract adds the two's complement of B
// as a 9-bit value so carry means "no borrow".
module sap_alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_result,
    output logic         o_carry
);
    logic [W:0] w_opb;
    logic [W:0] w_sum;
    assign w_opb = i_sub ? {1'b0, ~i_b} + (W+1)'(1) : {1'b0, i_b};
    assign w_sum = {1'b0, i_a} + w_opb;
    assign o_result = w_sum[W-1:0];
    assign o_carry  = w_sum[W];
endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 responder executing the 16-bit control word (registers, RAM, ALU, bus).
// Optional SAP_BUS_CHECK_EN adds a sticky multi-driver bus error.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int    DATA_W   = 8,
    parameter int    ADDR_W   = 4,
    parameter string MEM_INIT = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ctrl,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        instruction,
    output logic [7:0]        flags,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] bus,
    output logic              halted,
    output logic              bus_error
);
    logic [ADDR_W-1:0] r_pc, r_mar;
    logic [DATA_W-1:0] r_ir, r_a, r_b, r_out;
    logic              r_c, r_z, r_halted;
    logic [DATA_W-1:0] r_ram [2**ADDR_W];
    logic [DATA_W-1:0] w_alu, w_bus;
    logic              w_carry, w_ram_we;

    sap_alu #(.W(DATA_W)) u_alu (
        .i_a(r_a), .i_b(r_b), .i_sub(ctrl[SU]), .o_result(w_alu), .o_carry(w_carry)
    );

    assign w_bus = ctrl[RO]  ? r_ram[r_mar] :
                   ctrl[SMO] ? w_alu :
                   ctrl[AO]  ? r_a :
                   ctrl[IO]  ? DATA_W'(r_ir[3:0]) :
                   ctrl[CO]  ? DATA_W'(r_pc) : '0;

    assign w_ram_we = reset ? prog_we : (!r_halted && ctrl[RI]);

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[reset ? prog_addr : r_mar] <= reset ? prog_data : w_bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_mar    <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (ctrl[MI]) r_mar <= w_bus[ADDR_W-1:0];
            if (ctrl[II]) r_ir <= w_bus;
            if (ctrl[AI]) r_a <= w_bus;
            if (ctrl[BI]) r_b <= w_bus;
            if (ctrl[OI]) r_out <= w_bus;
            if (ctrl[FI]) begin
                r_c <= w_carry;
                r_z <= (w_alu == '0);
            end
            if (ctrl[JE]) r_pc <= w_bus[ADDR_W-1:0];
            else if (ctrl[CE]) r_pc <= r_pc + 1'b1;
            if (ctrl[HALT]) r_halted <= 1'b1;
        end
    end

`ifdef SAP_BUS_CHECK_EN
    logic r_bus_error;
    logic w_multi;
    assign w_multi = $countones({ctrl[RO], ctrl[SMO], ctrl[AO], ctrl[IO], ctrl[CO]}) > 1;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_error <= 1'b0;
        end else if (!r_halted && w_multi) begin
            r_bus_error <= 1'b1;
            $error("sap_datapath bus conflict ctrl=%h", ctrl);
        end
    end
    assign bus_error = r_bus_error;
`else
    assign bus_error = 1'b0;
`endif

    assign instruction = r_ir[DATA_W-1 -: 4];
    assign flags       = {r_c, r_z, 6'b0};
    assign out_value   = r_out;
    assign bus         = w_bus;
    assign halted      = r_halted;
endmodule
